// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared definitions for the clk_div_bank divided-clock generator.
//   - default widths for the master counter and the per-channel ratio selects
//   - per-channel FSM state encoding
//   - clamp helper that keeps a ratio select inside the master counter width
package clkgen_pkg;

    localparam int NUM_CH_DEF = 3;
    localparam int CNT_W_DEF  = 8;
    localparam int SEL_W_DEF  = 3;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } ch_state_t;

    // A select k divides by 2^(k+1); bit k of the counter must exist, so
    // anything at or beyond the counter width is pulled down to the top bit.
    function automatic int clamp_sel(input int sel, input int cnt_w);
        return (sel >= cnt_w) ? cnt_w - 1 : sel;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divided-clock output of clk_div_bank.
//   Follows bit k of the shared master counter (inverted, one cycle late) so the
//   output is high for the first half of each 2^(k+1) period. Starting and
//   stopping only happen on a period boundary, so no runt pulses are produced.
//   Optional feature macro: CLKGEN_STROBE_EN (one-cycle pulse on each rising edge).
// Ports:
//   clk_32f   master clock
//   reset     synchronous active-high reset
//   i_cnt     shared master counter
//   i_k       ratio select for this channel (already clamped)
//   i_en      run request
//   o_clk     divided clock (registered)
//   o_active  channel in RUN or STOPPING
//   o_strobe  rising-edge pulse, 0 when the strobe feature is not built
module clk_div_channel
    import clkgen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [SEL_W-1:0] i_k,
    input  logic             i_en,
    output logic             o_clk,
    output logic             o_active,
    output logic             o_strobe
);

    ch_state_t        r_state;
    logic             r_clk;
    logic             r_active;
    logic [CNT_W-1:0] w_mask;
    logic             w_bnd;
    logic             w_hi;

    // Mask of cnt[k:0]; the boundary is the last cycle of the current period.
    always_comb begin
        w_mask = '0;
        for (int j = 0; j < CNT_W; j++) begin
            w_mask[j] = (j <= int'(i_k));
        end
    end

    assign w_bnd = &(i_cnt | ~w_mask);
    assign w_hi  = ~i_cnt[i_k];

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state  <= ST_OFF;
            r_clk    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_clk <= (r_state == ST_RUN || r_state == ST_STOP) ? w_hi : 1'b0;
            case (r_state)
                ST_OFF: begin
                    if (i_en) r_state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!i_en) begin
                        r_state <= ST_OFF;
                    end else if (w_bnd) begin
                        r_state  <= ST_RUN;
                        r_active <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Dropping the request right on the boundary ends the
                    // output immediately; the low half has just completed.
                    if (!i_en) begin
                        if (w_bnd) begin
                            r_state  <= ST_OFF;
                            r_active <= 1'b0;
                        end else begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (i_en) begin
                        r_state <= ST_RUN;
                    end else if (w_bnd) begin
                        r_state  <= ST_OFF;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_OFF;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_clk    = r_clk;
    assign o_active = r_active;

`ifdef CLKGEN_STROBE_EN
    logic r_strobe;

    // Registered alongside r_clk, so the pulse lands on the cycle the output rises.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= (r_state == ST_RUN) && w_hi && !r_clk;
        end
    end

    assign o_strobe = r_strobe;
`else
    assign o_strobe = 1'b0;
`endif

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH phase-aligned 50%-duty clocks divided from clk_32f.
//   All channels derive from one free-running master counter, so rising edges of
//   any two channels coincide whenever the lower bits of the counter are zero.
//   A new ratio set is accepted through a valid/ready handshake and applied on
//   the master wrap, where every channel's period ends together.
//   Optional feature macro: CLKGEN_STROBE_EN (per-channel rising-edge strobe).
// Ports:
//   clk_32f    master clock
//   reset      synchronous active-high reset
//   ch_en      per-channel run request
//   cfg_valid  new ratio set offered
//   cfg_sel    new selects, ch0 in the LSBs
//   cfg_ready  high when no config is pending
//   clk_out    divided clocks (registered)
//   active     channel in RUN or STOPPING
//   strobe     one-cycle rising-edge pulse (0 unless CLKGEN_STROBE_EN)
module clk_div_bank
    import clkgen_pkg::*;
#(
    parameter int                      NUM_CH      = NUM_CH_DEF,
    parameter int                      CNT_W       = CNT_W_DEF,
    parameter int                      SEL_W       = SEL_W_DEF,
    parameter logic [NUM_CH*SEL_W-1:0] DEFAULT_SEL = {3'd2, 3'd3, 3'd4}
) (
    input  logic                    clk_32f,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    cfg_valid,
    input  logic [NUM_CH*SEL_W-1:0] cfg_sel,
    output logic                    cfg_ready,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       active,
    output logic [NUM_CH-1:0]       strobe
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]             r_cnt;
    logic [NUM_CH-1:0][SEL_W-1:0] r_sel;
    logic [NUM_CH-1:0][SEL_W-1:0] r_pend;
    logic                         r_cfg_ready;

    function automatic logic [NUM_CH-1:0][SEL_W-1:0] clamp_all(
        input logic [NUM_CH-1:0][SEL_W-1:0] s
    );
        logic [NUM_CH-1:0][SEL_W-1:0] c;
        for (int i = 0; i < NUM_CH; i++) begin
            c[i] = SEL_W'(clamp_sel(int'(s[i]), CNT_W));
        end
        return c;
    endfunction

    // The apply branch only fires with a config pending (ready low), so an
    // offer accepted on the wrap cycle itself waits for the following wrap.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_cnt       <= '0;
            r_sel       <= clamp_all(DEFAULT_SEL);
            r_pend      <= '0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (!r_cfg_ready && r_cnt == CNT_MAX) begin
                r_sel       <= clamp_all(r_pend);
                r_cfg_ready <= 1'b1;
            end else if (cfg_valid && r_cfg_ready) begin
                r_pend      <= cfg_sel;
                r_cfg_ready <= 1'b0;
            end
        end
    end

    assign cfg_ready = r_cfg_ready;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        clk_div_channel #(
            .CNT_W (CNT_W),
            .SEL_W (SEL_W)
        ) u_ch (
            .clk_32f  (clk_32f),
            .reset    (reset),
            .i_cnt    (r_cnt),
            .i_k      (r_sel[gi]),
            .i_en     (ch_en[gi]),
            .o_clk    (clk_out[gi]),
            .o_active (active[gi]),
            .o_strobe (strobe[gi])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: a period/phase model of each channel is stepped every
// clock and compared against clk_out/active/strobe/cfg_ready after each edge.
module tb_clk_div_bank;

    localparam logic [8:0] DEF = {3'd2, 3'd3, 3'd4};
`ifdef CLKGEN_STROBE_EN
    localparam bit STB = 1'b1;
`else
    localparam bit STB = 1'b0;
`endif

    logic       clk_32f = 1'b0;
    logic       reset;
    logic [2:0] ch_en;
    logic       cfg_valid;
    logic [8:0] cfg_sel;
    logic       cfg_ready;
    logic [2:0] clk_out, active, strobe;

    int checks = 0;
    int errors = 0;

    // model state
    int         m_cnt;
    int         m_sel [3];
    int         m_pend[3];
    bit         m_rdy;
    bit         m_armed[3], m_run[3], m_stop[3];
    logic [2:0] e_clk, e_act, e_stb;

    clk_div_bank dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_sel   (cfg_sel),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .active    (active),
        .strobe    (strobe)
    );

    always #5 clk_32f = ~clk_32f;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Channel i divides by 2^(k+1); it is high for the first half of the
    // period (phase < period/2), seen one clock later on clk_out.
    task automatic step_model();
        int per, ph;
        bit bnd, hi, nclk, en;
        if (reset) begin
            m_cnt = 0;
            m_rdy = 1'b1;
            for (int i = 0; i < 3; i++) begin
                m_sel[i] = DEF[i*3 +: 3];
                m_pend[i] = 0;
                m_armed[i] = 0; m_run[i] = 0; m_stop[i] = 0;
            end
            e_clk = '0; e_act = '0; e_stb = '0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            per  = 2 << m_sel[i];
            ph   = m_cnt % per;
            bnd  = (ph == per - 1);
            hi   = (ph < per / 2);
            en   = ch_en[i];
            nclk = (m_run[i] || m_stop[i]) ? hi : 1'b0;
            e_stb[i] = STB && m_run[i] && nclk && !e_clk[i];
            e_clk[i] = nclk;
            if (m_armed[i]) begin
                if (!en) m_armed[i] = 0;
                else if (bnd) begin m_armed[i] = 0; m_run[i] = 1; end
            end else if (m_run[i]) begin
                if (!en) begin m_run[i] = 0; m_stop[i] = !bnd; end
            end else if (m_stop[i]) begin
                if (en) begin m_stop[i] = 0; m_run[i] = 1; end
                else if (bnd) m_stop[i] = 0;
            end else if (en) begin
                m_armed[i] = 1;
            end
            e_act[i] = m_run[i] || m_stop[i];
        end
        if (!m_rdy && m_cnt == 255) begin
            for (int i = 0; i < 3; i++) m_sel[i] = (m_pend[i] >= 8) ? 7 : m_pend[i];
            m_rdy = 1'b1;
        end else if (cfg_valid && m_rdy) begin
            for (int i = 0; i < 3; i++) m_pend[i] = int'(cfg_sel[i*3 +: 3]);
            m_rdy = 1'b0;
        end
        m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic tick();
        @(posedge clk_32f);
        step_model();
        @(negedge clk_32f);
    endtask

    task automatic test_reset();
        reset = 1'b1; ch_en = 3'b111; cfg_valid = 1'b1; cfg_sel = 9'h1ff;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if ({clk_out, active, strobe, cfg_ready} !== 10'b0000000001) begin
                errors++;
                $display("FAIL reset_state got %b exp %b", {clk_out, active, strobe, cfg_ready}, 10'b0000000001);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_defaults();
        logic [2:0] prev;
        int rises[3];
        int srise;
        reset = 1'b0; ch_en = 3'b111;
        for (int n = 0; n < 48; n++) begin
            tick();
            checks++;
            if ({clk_out, active, strobe, cfg_ready} !== {e_clk, e_act, e_stb, m_rdy}) begin
                errors++;
                $display("FAIL defaults cyc %0d got %b exp %b", n, {clk_out, active, strobe, cfg_ready}, {e_clk, e_act, e_stb, m_rdy});
            end
        end
        prev = clk_out; rises = '{0, 0, 0}; srise = 0;
        for (int n = 0; n < 64; n++) begin
            tick();
            for (int i = 0; i < 3; i++) if (clk_out[i] && !prev[i]) rises[i]++;
            if (strobe[2]) srise++;
            prev = clk_out;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rises[i] !== (64 >> (5 - i))) begin
                errors++;
                $display("FAIL default_rises ch%0d got %0d exp %0d", i, rises[i], 64 >> (5 - i));
            end
        end
        checks++;
        if (srise !== (STB ? 8 : 0)) begin
            errors++;
            $display("FAIL strobe2_count got %0d exp %0d", srise, STB ? 8 : 0);
        end
    endtask

    task automatic test_disable();
        int n;
        int gaps;
        while (m_cnt % 32 != 5) tick();
        ch_en[0] = 1'b0;
        for (n = 0; n < 64 && active[0] !== 1'b0; n++) begin
            tick();
            checks++;
            if ({clk_out, active, strobe, cfg_ready} !== {e_clk, e_act, e_stb, m_rdy}) begin
                errors++;
                $display("FAIL disable got %b exp %b", {clk_out, active, strobe, cfg_ready}, {e_clk, e_act, e_stb, m_rdy});
            end
        end
        checks++;
        if (active[0] !== 1'b0 || clk_out[0] !== 1'b0 || (m_cnt % 32) != 0) begin
            errors++;
            $display("FAIL disable_stop act %b clk %b at cnt%%32=%0d exp 0 0 at 0", active[0], clk_out[0], m_cnt % 32);
        end
        ch_en[0] = 1'b1;
        for (int k = 0; k < 40; k++) tick();
        while (m_cnt % 32 != 5) tick();
        ch_en[0] = 1'b0;
        while (m_cnt % 32 != 20) tick();
        ch_en[0] = 1'b1;
        gaps = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (active[0] !== 1'b1) gaps++;
            checks++;
            if ({clk_out, active, strobe, cfg_ready} !== {e_clk, e_act, e_stb, m_rdy}) begin
                errors++;
                $display("FAIL reenable got %b exp %b", {clk_out, active, strobe, cfg_ready}, {e_clk, e_act, e_stb, m_rdy});
            end
        end
        checks++;
        if (gaps !== 0) begin
            errors++;
            $display("FAIL reenable_gap got %0d inactive cycles exp 0", gaps);
        end
    endtask

    task automatic test_reconfig();
        logic [2:0] prev;
        int rises[3];
        while (m_cnt != 100) tick();
        cfg_valid = 1'b1; cfg_sel = {3'd1, 3'd1, 3'd0};
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ready_drop got %b exp 0", cfg_ready);
        end
        while (m_cnt != 110) tick();
        cfg_valid = 1'b1; cfg_sel = {3'd7, 3'd7, 3'd7};
        tick();
        cfg_valid = 1'b0;
        while (m_cnt != 0) begin
            tick();
            checks++;
            if ({clk_out, active, strobe, cfg_ready} !== {e_clk, e_act, e_stb, m_rdy}) begin
                errors++;
                $display("FAIL reconfig cnt %0d got %b exp %b", m_cnt, {clk_out, active, strobe, cfg_ready}, {e_clk, e_act, e_stb, m_rdy});
            end
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready_return got %b exp 1", cfg_ready);
        end
        prev = clk_out; rises = '{0, 0, 0};
        for (int n = 0; n < 16; n++) begin
            tick();
            for (int i = 0; i < 3; i++) if (clk_out[i] && !prev[i]) rises[i]++;
            prev = clk_out;
        end
        checks++;
        if (rises[0] !== 8 || rises[1] !== 4 || rises[2] !== 4) begin
            errors++;
            $display("FAIL reconfig_rises got %0d/%0d/%0d exp 8/4/4", rises[0], rises[1], rises[2]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(63) == 0) ch_en[$urandom_range(2)] ^= 1'b1;
            cfg_valid = ($urandom_range(49) == 0);
            cfg_sel   = 9'($urandom);
            tick();
            checks++;
            if ({clk_out, active, strobe, cfg_ready} !== {e_clk, e_act, e_stb, m_rdy}) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b", n, {clk_out, active, strobe, cfg_ready}, {e_clk, e_act, e_stb, m_rdy});
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [2:0] prev;
        int rises[3];
        ch_en = 3'b111;
        for (int n = 0; n < 300 && !m_rdy; n++) tick();
        for (int n = 0; n < 20; n++) tick();
        cfg_valid = 1'b1; cfg_sel = 9'h000;
        tick();
        cfg_valid = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if ({clk_out, active, strobe, cfg_ready} !== 10'b0000000001) begin
            errors++;
            $display("FAIL midop_reset got %b exp %b", {clk_out, active, strobe, cfg_ready}, 10'b0000000001);
        end
        reset = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            checks++;
            if ({clk_out, active, strobe, cfg_ready} !== {e_clk, e_act, e_stb, m_rdy}) begin
                errors++;
                $display("FAIL after_reset cyc %0d got %b exp %b", n, {clk_out, active, strobe, cfg_ready}, {e_clk, e_act, e_stb, m_rdy});
            end
        end
        prev = clk_out; rises = '{0, 0, 0};
        for (int n = 0; n < 64; n++) begin
            tick();
            for (int i = 0; i < 3; i++) if (clk_out[i] && !prev[i]) rises[i]++;
            prev = clk_out;
        end
        checks++;
        if (rises[0] !== 2 || rises[1] !== 4 || rises[2] !== 8) begin
            errors++;
            $display("FAIL midop_default_rises got %0d/%0d/%0d exp 2/4/8", rises[0], rises[1], rises[2]);
        end
    endtask

    initial begin
        reset = 1'b1; ch_en = '0; cfg_valid = 1'b0; cfg_sel = '0;
        m_cnt = 0; m_rdy = 1'b1; e_clk = '0; e_act = '0; e_stb = '0;
        test_reset();
        test_defaults();
        test_disable();
        test_reconfig();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
